// File: rtl/decim_pkg.sv
// Shared types and constants for the decimated-sample framer.
// FSM state enum, frame header byte and sample width.
package decim_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_MSB  = 2'd2,
    ST_LSB  = 2'd3
  } state_e;

endpackage

// File: rtl/decim_sample_fifo.sv
// Synchronous sample FIFO with flush; rdata always shows the head entry.
// Ports: clk, rst_n, flush, push, pop, wdata, rdata, full, empty, level.
module decim_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  // A push while full is legal only when the head leaves in the same cycle.
  assign do_push = push && !flush && (level_q != FULL_LVL || do_pop);
  assign do_pop  = pop && !flush && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case (1'b1)
        (do_push && !do_pop): level_d = level_q + 1'b1;
        (do_pop && !do_push): level_d = level_q - 1'b1;
        default:              level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/decim_sample_framer.sv
// Buffers decimated samples and streams each as MSB/LSB bytes (valid/ready).
// Ports: clk, rst_n, flush, in_valid, in_data, out_byte/valid/ready/last,
// overflow, drop_count, fifo_level. Option: DECIM_FRAMER_HEADER_EN adds A5 header.
module decim_sample_framer
  import decim_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

`ifdef DECIM_FRAMER_HEADER_EN
  localparam state_e FIRST_ST = ST_HDR;
`else
  localparam state_e FIRST_ST = ST_MSB;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [7:0]        out_byte_q, out_byte_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_count_q, drop_count_d;

  logic              push, pop, drop;
  logic              full, empty;
  logic [DATA_W-1:0] head;

  decim_sample_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_comb begin
    pop = 1'b0;
    if (!flush && !empty) begin
      case (state_q)
        ST_IDLE: pop = 1'b1;
        ST_LSB:  pop = out_ready;
        default: pop = 1'b0;
      endcase
    end
  end

  assign push = in_valid && !flush && (!full || pop);
  assign drop = in_valid && !flush && full && !pop;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    overflow_d   = overflow_q | drop;
    drop_count_d = drop_count_q;
    if (drop && drop_count_q != '1) drop_count_d = drop_count_q + 1'b1;
    if (flush) begin
      state_d      = ST_IDLE;
      hold_d       = '0;
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            hold_d  = head;
            state_d = FIRST_ST;
          end
        end
        ST_HDR: if (out_ready) state_d = ST_MSB;
        ST_MSB: if (out_ready) state_d = ST_LSB;
        ST_LSB: begin
          if (out_ready) begin
            if (pop) begin
              hold_d  = head;
              state_d = FIRST_ST;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so a fresh frame is
  // visible the cycle after the pop, with no bubble between frames.
  always_comb begin
    out_byte_d  = 8'h00;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    case (state_d)
      ST_HDR: begin
        out_byte_d  = FRAME_HDR;
        out_valid_d = 1'b1;
      end
      ST_MSB: begin
        out_byte_d  = hold_d[15:8];
        out_valid_d = 1'b1;
      end
      ST_LSB: begin
        out_byte_d  = hold_d[7:0];
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      out_byte_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      out_byte_q   <= out_byte_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_byte   = out_byte_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: doc/decim_sample_framer.md
Name: decim_sample_framer

Overview:
Downstream stage of the decimation filter. It captures each 16-bit decimated output word when its valid strobe fires and buffers the word in a small FIFO. It then streams the word out as two bytes, MSB first, over an 8-bit valid/ready interface, so a slow off-chip reader can consume samples without losing them. Overflow is detected, counted and flagged.

Parameters:
DATA_W, 16, sample width; fixed at 2 bytes, other values unsupported.
DEPTH, 4, FIFO depth in samples; power of 2, minimum 2.
CNT_W, 8, width of the saturating drop counter.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of FIFO, serializer and flags
in_valid  in  1  single-cycle strobe: in_data holds a new decimated sample
in_data  in  16  decimated sample (unsigned)
out_byte  out  8  current output byte
out_valid  out  1  out_byte is valid
out_ready  in  1  consumer accepts out_byte this cycle when high with out_valid
out_last  out  1  high on the final byte of a sample frame
overflow  out  1  sticky: a sample was dropped
drop_count  out  CNT_W  number of dropped samples, saturating
fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, pointers 0, FSM IDLE, out_byte=0, out_valid=0, out_last=0, overflow=0, drop_count=0, fifo_level=0.
- flush (synchronous) has top priority. The next state equals the reset state, and in_valid in the same cycle is ignored.
- Push: when in_valid=1, the FIFO is not full, and there is no flush, in_data is written and the level increments.
- Full: when in_valid=1 and the FIFO is full with no pop in the same cycle, the sample is dropped, overflow is set, and drop_count increments, saturating at 2^CNT_W-1.
- Push and pop in the same cycle: both occur. A push while full is accepted if a pop happens in that cycle. The level is unchanged.
- FSM states: IDLE, MSB, LSB, plus HDR when the optional feature is enabled.
  - IDLE: if the FIFO is not empty, pop the head into the 16-bit hold register and go to MSB. Without the option the next state is MSB; with it, HDR.
  - MSB: out_byte=hold[15:8], out_valid=1, out_last=0. On out_ready go to LSB.
  - LSB: out_byte=hold[7:0], out_valid=1, out_last=1. On out_ready, if the FIFO is not empty, pop the head into hold and go to MSB (or HDR). Otherwise go to IDLE.
- out_byte, out_valid and out_last are registered outputs decoded from state and hold.
- Latency: a push into an empty FIFO with the FSM in IDLE gives out_valid=1 two cycles after the in_valid edge (push cycle N, pop N+1, byte visible N+2). Back-to-back frames have no bubble cycle.
- While out_valid=1 and out_ready=0, out_byte and out_last hold stable (AXI-style; no retraction).
- out_ready while out_valid=0 has no effect.
- FIFO pointers wrap modulo DEPTH. fifo_level counts 0..DEPTH.
- A pop takes the head entry only, so FIFO order is preserved.

Optional Feature:
Macro: DECIM_FRAMER_HEADER_EN.
- Defined: each frame is preceded by HDR state, with out_byte=8'hA5 and out_last=0. On out_ready the FSM goes to MSB. A frame is 3 bytes.
- Undefined: no HDR state exists, and a frame is 2 bytes.
- Latency and the overflow rules are otherwise identical.

Decomposition:
- Shared package decim_pkg holds:
  - the FSM state enum (IDLE, HDR, MSB, LSB);
  - the constant FRAME_HDR=8'hA5;
  - the constant SAMPLE_W=16, matched to the decimation filter output width.
- One sub-module, decim_sample_fifo: a synchronous FIFO with push, pop, full, empty, level and flush. The framer contains the FSM, the hold register and the drop accounting.

Test Plan:
- Reset, then in_valid with in_data=16'h1234 and out_ready held at 1 -> 2 cycles later out_byte=8'h12 (out_last=0), next cycle out_byte=8'h34 (out_last=1), then out_valid=0.
- out_ready=0 with 16'hBEEF pushed -> out_byte=8'hBE and out_valid=1 held for 10 cycles unchanged; after out_ready is raised, 8'hEF follows.
- With DEPTH=4 and out_ready=0, push 6 samples 1..6 -> fifo_level=4 after the serializer loads sample 1 into hold, overflow=1, drop_count=1. Draining outputs samples 1..5 in order and sample 6 is lost.
- Full FIFO, in_valid in the same cycle as the LSB accept (pop) -> new sample accepted, overflow unchanged, fifo_level unchanged.
- Assert flush mid-frame (in LSB state) with 3 samples queued -> next cycle out_valid=0, fifo_level=0, overflow=0, drop_count=0. rst_n pulsed low mid-frame -> outputs clear immediately, without waiting for a clock edge.
- With DECIM_FRAMER_HEADER_EN, push 16'h00FF -> byte sequence A5, 00, FF with out_last only on FF.
